// File: rtl/mem_resp_sram.sv
// Single-port word scratchpad acting as the responder for the core's data-memory
// valid/ready request port; every accepted request yields one rvalid pulse.
module mem_resp_sram #(
  parameter int unsigned Xlen       = 32,
  parameter int unsigned Depth      = 1024,
  parameter int unsigned Latency    = 1,
  parameter int unsigned ReadyDelay = 0,
  localparam int unsigned MaskBits  = Xlen / 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [Xlen-1:0]     mem_addr_i,
  input  logic [Xlen-1:0]     mem_wdata_i,
  input  logic [MaskBits-1:0] mem_wmask_i,
  output logic [Xlen-1:0]     mem_rdata_o,
  output logic                mem_rvalid_o
);

  localparam int unsigned IdxW      = $clog2(Depth);
  localparam int unsigned OffW      = $clog2(MaskBits);
  localparam logic [3:0]  StallInit = 4'(ReadyDelay - 32'd1);
  localparam logic [3:0]  BusyInit  = 4'(Latency - 32'd2);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Stall = 2'd1,
    Busy  = 2'd2,
    Resp  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [Xlen-1:0]   rdata_q, rdata_d;
  logic [Xlen-1:0]   mem_q [Depth];
  logic [IdxW-1:0]   idx_s;
  logic              is_load_s;
  logic              ready_s;
  logic              accept_s;
  logic              unused_addr_s;

  // Byte-select bits and bits above the array size are ignored (aliasing).
  assign idx_s         = mem_addr_i[OffW +: IdxW];
  assign unused_addr_s = ^{mem_addr_i[Xlen-1:OffW+IdxW], mem_addr_i[OffW-1:0]};
  assign is_load_s     = (mem_wmask_i == '0);

  // Next-state, counter, handshake and response-register logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    ready_s  = 1'b0;
    accept_s = 1'b0;
    case (state_q)
      Idle: begin
        ready_s = (ReadyDelay == 32'd0);
        if (mem_valid_i) begin
          if (ReadyDelay == 32'd0) begin
            accept_s = 1'b1;
          end else begin
            state_d = Stall;
            cnt_d   = StallInit;
          end
        end else begin
          state_d = Idle;
        end
      end
      Stall: begin
        ready_s = (cnt_q == 4'd0);
        if (!mem_valid_i) begin
          state_d = Idle;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          accept_s = 1'b1;
        end
      end
      Busy: begin
        if (cnt_q == 4'd0) begin
          state_d = Resp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      Resp: begin
        state_d = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
    // Acceptance overrides the per-state update: capture response, start latency.
    if (accept_s) begin
      rdata_d = is_load_s ? mem_q[idx_s] : '0;
      if (Latency == 32'd1) begin
        state_d = Resp;
      end else begin
        state_d = Busy;
        cnt_d   = BusyInit;
      end
    end else begin
      rdata_d = rdata_d;
    end
  end

  // Control state and response register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-masked store into the array; contents survive reset
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      for (int i = 0; i < MaskBits; i++) begin
        if (mem_wmask_i[i]) begin
          mem_q[idx_s][i*8 +: 8] <= mem_wdata_i[i*8 +: 8];
        end
      end
    end
  end

  assign mem_ready_o  = ready_s & rst_ni;
  assign mem_rvalid_o = (state_q == Resp);
  assign mem_rdata_o  = rdata_q;

endmodule

// File: tb/tb_mem_resp_sram.sv
// Scoreboard bench for mem_resp_sram: three instances with different ready-delay
// and latency settings, expected responses queued at acceptance and checked on rvalid.
module tb_mem_resp_sram;

  localparam int NI = 3;
  localparam int LAT [NI] = '{1, 4, 5};
  localparam int RD  [NI] = '{0, 3, 2};

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid  [NI];
  logic        ready  [NI];
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic [3:0]  wmask  [NI];
  logic [31:0] rdata  [NI];
  logic        rvalid [NI];

  exp_t exp_q [NI][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_resp_sram #(
      .Xlen(32), .Depth(1024), .Latency(LAT[g]), .ReadyDelay(RD[g])
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mem_valid_i (valid[g]),
      .mem_ready_o (ready[g]),
      .mem_addr_i  (addr[g]),
      .mem_wdata_i (wdata[g]),
      .mem_wmask_i (wmask[g]),
      .mem_rdata_o (rdata[g]),
      .mem_rvalid_o(rvalid[g])
    );

    // Monitor: every rvalid must match the oldest queued expectation in data and cycle.
    exp_t e;
    always @(negedge clk) begin
      if (rvalid[g] === 1'b1) begin
        checks++;
        if (exp_q[g].size() == 0) begin
          errors++;
          $display("FAIL rsp%0d_unexpected: rvalid at cyc %0d rdata %h, none expected", g, cyc, rdata[g]);
        end else begin
          e = exp_q[g].pop_front();
          if (rdata[g] !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp%0d: rdata %h at cyc %0d, expected %h at cyc %0d",
                     g, rdata[g], cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Issue one request, wait (bounded) for ready, queue the expected response.
  task automatic do_req(input int g, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input logic [31:0] ed,
                        input bit expect_resp, output int waited);
    exp_t x;
    waited = 0;
    @(negedge clk);
    valid[g] = 1'b1; addr[g] = a; wdata[g] = wd; wmask[g] = m;
    while (ready[g] !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (ready[g] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL req%0d_timeout: ready %b after %0d cycles, expected 1", g, ready[g], waited);
      valid[g] = 1'b0;
    end else begin
      if (expect_resp) begin
        x.data = ed;
        x.cyc  = cyc + LAT[g];
        exp_q[g].push_back(x);
      end
      @(posedge clk);
      #1;
      valid[g] = 1'b0; addr[g] = 32'hFFFF_FFFC; wdata[g] = 32'h5A5A_5A5A; wmask[g] = 4'hF;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wmask[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, ready[0]}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid[0]}, 32'd0);
    chk("rst_rdata0", rdata[0], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready0", {31'd0, ready[0]}, 32'd1);
    chk("post_rst_ready1", {31'd0, ready[1]}, 32'd0);

    // Latency 1: store then back-to-back load of the same word
    do_req(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, n);
    do_req(0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1, n);
    chk("b2b_wait", n, 32'd1);
    // Byte / half masks
    do_req(0, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b1, n);
    do_req(0, 32'h20, 32'h0000_00AA, 4'h1, 32'h0, 1'b1, n);
    do_req(0, 32'h20, 32'hBBCC_0000, 4'hC, 32'h0, 1'b1, n);
    do_req(0, 32'h20, 32'h0, 4'h0, 32'hBBCC_33AA, 1'b1, n);
    // Aliasing and ignored byte-select bits
    do_req(0, 32'h0, 32'h0000_0055, 4'hF, 32'h0, 1'b1, n);
    do_req(0, 32'h1000, 32'h0, 4'h0, 32'h0000_0055, 1'b1, n);
    do_req(0, 32'h3, 32'h0, 4'h0, 32'h0000_0055, 1'b1, n);

    // Latency 4 / ReadyDelay 3: ready only in cycle 3, rvalid in cycle 7
    @(negedge clk);
    valid[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'hCAFE_F00D; wmask[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3 && ready[1] === 1'b1) begin
        exp_q[1].push_back('{data: 32'h0, cyc: cyc + 4});
      end
      chk($sformatf("rd3_ready_c%0d", i), {31'd0, ready[1]}, (i == 3) ? 32'd1 : 32'd0);
      if (i == 4) begin
        addr[1] = 32'h44; wdata[1] = 32'hFFFF_FFFF;
      end
      if (i == 7) valid[1] = 1'b0;
    end
    do_req(1, 32'h40, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, n);
    chk("rd3_wait", n, 32'd3);

    // Abandon in Stall (ReadyDelay 2): no write, no response
    do_req(2, 32'h80, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b1, n);
    repeat (8) @(negedge clk);
    valid[2] = 1'b1; addr[2] = 32'h80; wdata[2] = 32'h1234_5678; wmask[2] = 4'hF;
    @(negedge clk);
    chk("abandon_stall_ready", {31'd0, ready[2]}, 32'd0);
    valid[2] = 1'b0;
    @(negedge clk);
    chk("abandon_idle_ready", {31'd0, ready[2]}, 32'd0);
    repeat (3) @(negedge clk);
    do_req(2, 32'h80, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b1, n);
    chk("abandon_then_wait", n, 32'd2);
    repeat (8) @(negedge clk);

    // Reset two cycles after a Latency-5 store is accepted
    do_req(2, 32'h90, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, n);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready0", {31'd0, ready[0]}, 32'd0);
    chk("midrst_rvalid2", {31'd0, rvalid[2]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_rel_ready0", {31'd0, ready[0]}, 32'd1);
    chk("midrst_rel_ready2", {31'd0, ready[2]}, 32'd0);
    repeat (10) @(negedge clk);
    do_req(2, 32'h90, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1, n);
    repeat (10) @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      chk($sformatf("drain%0d", i), exp_q[i].size(), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
